// File: rtl/result_drain.sv
// Drains DEPTH words from a result RAM (one-cycle read latency) onto a valid/ready stream, one frame per start.
// Define RESULT_DRAIN_CHECKSUM_EN to enable the modulo-256 frame checksum; otherwise checksum is tied to 0.
module result_drain #(
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  output logic          rd_en,
  output logic [AW-1:0] rd_addb,
  input  logic [7:0]    rd_data,
  output logic [7:0]    dout,
  output logic          dout_valid,
  input  logic          dout_ready,
  output logic          busy,
  output logic          done,
  output logic [7:0]    checksum
);

  typedef enum logic [2:0] {IDLE, ADDR, CAPT, SEND, DONE} state_t;

  localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);

  state_t        state_reg;
  logic [AW-1:0] idx_reg;

  // All outputs are registered; each is set on the edge that enters the state it belongs to.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg  <= IDLE;
      idx_reg    <= '0;
      rd_en      <= 1'b0;
      rd_addb    <= '0;
      dout       <= 8'h00;
      dout_valid <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (start) begin
            state_reg <= ADDR;
            idx_reg   <= '0;
            rd_en     <= 1'b1;
            rd_addb   <= '0;
            busy      <= 1'b1;
          end
        end
        ADDR: begin
          state_reg <= CAPT;
          rd_en     <= 1'b0;
        end
        CAPT: begin
          state_reg  <= SEND;
          dout       <= rd_data;
          dout_valid <= 1'b1;
        end
        SEND: begin
          if (dout_ready) begin
            dout_valid <= 1'b0;
            if (idx_reg == LAST_IDX) begin
              state_reg <= DONE;
              done      <= 1'b1;
            end else begin
              state_reg <= ADDR;
              idx_reg   <= idx_reg + 1'b1;
              rd_en     <= 1'b1;
              rd_addb   <= idx_reg + 1'b1;
            end
          end
        end
        DONE: begin
          state_reg <= IDLE;
          done      <= 1'b0;
          busy      <= 1'b0;
        end
        default: begin
          state_reg  <= IDLE;
          rd_en      <= 1'b0;
          dout_valid <= 1'b0;
          busy       <= 1'b0;
          done       <= 1'b0;
        end
      endcase
    end
  end

`ifdef RESULT_DRAIN_CHECKSUM_EN
  logic [7:0] sum_reg;

  // The running sum doubles as the output: it reaches its final value entering DONE and holds until the next start.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sum_reg <= 8'h00;
    end else if (state_reg == IDLE && start) begin
      sum_reg <= 8'h00;
    end else if (state_reg == SEND && dout_ready) begin
      sum_reg <= sum_reg + dout;
    end
  end

  assign checksum = sum_reg;
`else
  assign checksum = 8'h00;
`endif

endmodule

// File: doc/result_drain.md
RESULT_DRAIN -- requirements
Module: result_drain

Interface
REQ-001 The block SHALL have parameter DEPTH, default 4, giving the number of result words drained per frame.
REQ-002 The block SHALL have parameter AW, default 2, giving the result-RAM address width; DEPTH SHALL equal 2**AW.
REQ-003 clk  input  1  single clock; all state SHALL change on its rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 start  input  1  request to drain one frame; sampled only in IDLE.
REQ-006 rd_en  output  1  result-RAM read strobe.
REQ-007 rd_addb  output  AW  result-RAM read address.
REQ-008 rd_data  input  8  result-RAM read data, valid on the cycle after rd_en.
REQ-009 dout  output  8  streamed result word.
REQ-010 dout_valid  output  1  dout holds a word.
REQ-011 dout_ready  input  1  the consumer accepts dout.
REQ-012 busy  output  1  a frame is in progress.
REQ-013 done  output  1  one-cycle pulse marking frame completion.
REQ-014 checksum  output  8  frame checksum, as defined under Configuration.

Function
REQ-015 The FSM SHALL have the states IDLE, ADDR, CAPT, SEND and DONE, with the following transitions:
- IDLE->ADDR when start=1.
- ADDR->CAPT unconditionally.
- CAPT->SEND unconditionally.
- SEND->ADDR on handshake when the index is below DEPTH-1.
- SEND->DONE on handshake when the index equals DEPTH-1.
- DONE->IDLE unconditionally.
REQ-016 In ADDR, rd_en SHALL be 1 and rd_addb SHALL equal the word index; in all other states rd_en SHALL be 0.
REQ-017 In CAPT, rd_data SHALL be registered into dout.
REQ-018 dout_valid SHALL be 1 exactly while in SEND.
REQ-019 dout SHALL be stable while dout_valid=1 and dout_ready=0.
REQ-020 A handshake SHALL occur on a rising edge where dout_valid=1 and dout_ready=1; the index SHALL then increment.
REQ-021 The index SHALL start at 0 at every frame start and SHALL never wrap within a frame.
REQ-022 After the edge sampling start, the first dout_valid SHALL rise after the second following edge; with dout_ready held at 1, words SHALL be delivered one per 3 cycles.
REQ-023 busy SHALL be 1 in all states except IDLE.
REQ-024 done SHALL be 1 for exactly the one cycle spent in DONE.
REQ-025 start SHALL be ignored outside IDLE, including the DONE cycle; no queuing of start SHALL occur.
REQ-026 dout_ready SHALL be ignored outside SEND.
REQ-027 Holding start=1 continuously SHALL produce back-to-back frames with exactly one IDLE cycle between them.

Reset
REQ-028 reset=0 SHALL immediately force IDLE, index 0, dout=0, dout_valid=0, rd_en=0, rd_addb=0, busy=0, done=0 and checksum=0, regardless of clock.
REQ-029 A reset asserted mid-frame SHALL abandon the frame without any done pulse; the next frame SHALL restart at index 0.
REQ-030 Reset deassertion SHALL be treated as synchronous to clk; the first start SHALL be honoured on the first rising edge after deassertion.

Configuration
REQ-031 With RESULT_DRAIN_CHECKSUM_EN defined:
- An 8-bit accumulator SHALL clear on frame start.
- On each handshake it SHALL add dout modulo 256.
- checksum SHALL present the final sum from the DONE cycle until the next frame start.
REQ-032 Without RESULT_DRAIN_CHECKSUM_EN, checksum SHALL be constant 0 and no accumulator logic SHALL exist.

Verification
REQ-033 Drain with ready always high: RAM={0x05,0x0A,0xFF,0x80}, pulse start -> dout sequence 05,0A,FF,80 at 3-cycle spacing, a single done pulse, and checksum=0x8E when the macro is enabled.
REQ-034 Backpressure: hold dout_ready=0 for 10 cycles on word 1 -> dout=0x0A stable with dout_valid=1 throughout, and no address advance.
REQ-035 Reset during word 2 of the frame above -> all outputs 0 immediately and no done; a new start -> dout begins at 0x05.
REQ-036 start=1 held continuously -> two consecutive frames, done pulses 14 cycles apart, and one IDLE cycle between frames.
REQ-037 start pulsed while busy and during DONE -> ignored, with exactly 4 words and 1 done per accepted start.
REQ-038 Build without the macro and rerun REQ-033 -> identical dout/done timing and checksum=0.
